// File: rtl/ks_prefix_pipe.sv
// ks_prefix_pipe: pipelined Kogge-Stone carry network with a registered sum stage.
// Inputs are per-bit generate/propagate vectors from a half-adder array.
// Stages 0..N-1 each hold one prefix level. Stage N holds the sum, carry-out and overflow.
// Each stage carries its own valid bit, so bubbles collapse and the execute stage can stall the pipe.
// Optional build macro KS_TAG_EN adds an in_tag/out_tag sideband that travels with each entry.
module ks_prefix_pipe #(
    parameter int WIDTH = 16
`ifdef KS_TAG_EN
    , parameter int TAG_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_p,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
`ifdef KS_TAG_EN
    , input  logic [TAG_W-1:0] in_tag
    , output logic [TAG_W-1:0] out_tag
`endif
);

    localparam int N = $clog2(WIDTH);
    localparam int L = N + 1;

    generate
        if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("ks_prefix_pipe: WIDTH must be a power of two and at least 4");
        end
    endgenerate

    // Prefix-level registers. praw/cin carry the original propagate vector and carry-in to the sum stage.
    logic [WIDTH-1:0] g_q    [N];
    logic [WIDTH-1:0] p_q    [N];
    logic [WIDTH-1:0] praw_q [N];
    logic [N-1:0]     cin_q;

    // Sum-stage registers
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // One valid bit per stage; index L-1 is the sum stage
    logic [L-1:0]     vld_q;

`ifdef KS_TAG_EN
    logic [TAG_W-1:0] tag_q   [L];
    logic [TAG_W-1:0] tag_src [L];
`endif

    // Upstream source of every stage and the combinational next values
    logic [WIDTH-1:0] g_src    [N];
    logic [WIDTH-1:0] p_src    [N];
    logic [WIDTH-1:0] praw_src [N];
    logic [N-1:0]     cin_src;
    logic [L-1:0]     vld_src;

    logic [WIDTH-1:0] g_d [N];
    logic [WIDTH-1:0] p_d [N];
    logic [WIDTH-1:0] low_mask;

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    logic [L-1:0]     adv;
    logic             adv_chain;

    // Advance chain: a stage moves when it is empty or the stage after it moves
    always_comb begin
        adv       = '0;
        adv_chain = out_ready;
        for (int s = L - 1; s >= 0; s--) begin
            adv[s]    = ~vld_q[s] | adv_chain;
            adv_chain = adv[s];
        end
    end

    // in_ready depends only on out_ready and the valid bits, never on in_valid
    assign in_ready = adv[0];

    // Route each stage's upstream source; the carry-in is folded into bit 0 at entry
    always_comb begin
        g_src[0]    = {in_g[WIDTH-1:1], in_g[0] | (in_p[0] & in_cin)};
        p_src[0]    = in_p;
        praw_src[0] = in_p;
        cin_src     = '0;
        cin_src[0]  = in_cin;
        vld_src     = '0;
        vld_src[0]  = in_valid;
        for (int s = 1; s < N; s++) begin
            g_src[s]    = g_q[s-1];
            p_src[s]    = p_q[s-1];
            praw_src[s] = praw_q[s-1];
            cin_src[s]  = cin_q[s-1];
            vld_src[s]  = vld_q[s-1];
        end
        vld_src[L-1] = vld_q[L-2];
    end

`ifdef KS_TAG_EN
    // Tag follows the same path as the valid bit
    always_comb begin
        tag_src[0] = in_tag;
        for (int s = 1; s < L; s++) begin
            tag_src[s] = tag_q[s-1];
        end
    end
`endif

    // Prefix level s combines bit i with bit i-2^s; bits below the distance pass through
    always_comb begin
        low_mask = '0;
        for (int s = 0; s < N; s++) begin
            low_mask = (WIDTH'(1) << (1 << s)) - WIDTH'(1);
            g_d[s]   = g_src[s] | (p_src[s] & (g_src[s] << (1 << s)));
            p_d[s]   = p_src[s] & ((p_src[s] << (1 << s)) | low_mask);
        end
    end

    // Sum stage: carry into bit i is the group generate of bits i-1..0 (including cin)
    always_comb begin
        carry  = {g_q[N-1][WIDTH-2:0], cin_q[N-1]};
        sum_d  = praw_q[N-1] ^ carry;
        cout_d = g_q[N-1][WIDTH-1];
        ovf_d  = g_q[N-1][WIDTH-1] ^ g_q[N-1][WIDTH-2];
    end

    // Valid bits: cleared by reset, otherwise shifted forward wherever a stage advances
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            for (int s = 0; s < L; s++) begin
                if (adv[s]) begin
                    vld_q[s] <= vld_src[s];
                end
            end
        end
    end

    // Data registers load only when a real entry moves in, so a stalled stage holds its value
    always_ff @(posedge clk) begin
        for (int s = 0; s < N; s++) begin
            if (adv[s] && vld_src[s]) begin
                g_q[s]    <= g_d[s];
                p_q[s]    <= p_d[s];
                praw_q[s] <= praw_src[s];
                cin_q[s]  <= cin_src[s];
            end
        end
        if (adv[L-1] && vld_src[L-1]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef KS_TAG_EN
    // Tag registers move in lockstep with their entry
    always_ff @(posedge clk) begin
        for (int s = 0; s < L; s++) begin
            if (adv[s] && vld_src[s]) begin
                tag_q[s] <= tag_src[s];
            end
        end
    end

    assign out_tag = vld_q[L-1] ? tag_q[L-1] : '0;
`endif

    // Data registers are not reset, so outputs are forced to zero whenever no result is presented
    assign out_valid = vld_q[L-1];
    assign out_sum   = vld_q[L-1] ? sum_q : '0;
    assign out_cout  = vld_q[L-1] & cout_q;
    assign out_ovf   = vld_q[L-1] & ovf_q;

endmodule

// File: tb/tb_ks_prefix_pipe.sv
// Bench for ks_prefix_pipe: directed vectors with literal expectations plus an
// arithmetic model (A+B+cin) feeding an in-order expected-result queue.
module tb_ks_prefix_pipe;

    localparam int W   = 16;
    localparam int TW  = 4;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_g;
    logic [W-1:0]  in_p;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic [TW-1:0] in_tag;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    ks_prefix_pipe #(
        .WIDTH(W)
`ifdef KS_TAG_EN
        , .TAG_W(TW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_g      (in_g),
        .in_p      (in_p),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
`ifdef KS_TAG_EN
        , .in_tag  (in_tag)
        , .out_tag (out_tag)
`endif
    );

`ifndef KS_TAG_EN
    assign out_tag = '0;
`endif

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic [TW-1:0] tag;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected result from the adder's arithmetic meaning. A legal half-adder pair
    // satisfies A+B = (A^B) + 2*(A&B); for g&p overlap fall back to the bitwise carry rule.
    function automatic res_t model(input logic [W-1:0] g, input logic [W-1:0] p,
                                   input logic cin, input logic [TW-1:0] tag);
        res_t r;
        logic [W+1:0] tot;
        logic c, c_prev;
        r     = '0;
        r.tag = tag;
        if ((g & p) == '0) begin
            tot    = {2'b00, p} + {1'b0, g, 1'b0} + (W+2)'(cin);
            r.sum  = tot[W-1:0];
            r.cout = tot[W];
            // operands share a sign bit only when p[msb]=0, and then that sign is g[msb]
            r.ovf  = ~p[W-1] & (r.sum[W-1] ^ g[W-1]);
        end else begin
            c      = cin;
            c_prev = cin;
            for (int i = 0; i < W; i++) begin
                r.sum[i] = p[i] ^ c;
                c_prev   = c;
                c        = g[i] | (p[i] & c);
            end
            r.cout = c;
            r.ovf  = c ^ c_prev;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] g, input logic [W-1:0] p,
                         input logic ci, input logic [TW-1:0] t);
        in_valid = v;
        in_g     = g;
        in_p     = p;
        in_cin   = ci;
        in_tag   = t;
    endtask

    task automatic drive_rand(input logic v);
        logic [W-1:0] a, b;
        a = W'($urandom);
        b = W'($urandom);
        drive(v, a & b, a ^ b, 1'($urandom_range(1)), TW'($urandom));
    endtask

    // Compare process: every negedge, check outputs against the expected queue,
    // check hold-stability under stall, and record accepted inputs.
    res_t act_r, prev_r;
    logic prev_hold = 1'b0;

    always @(negedge clk) begin
        act_r = '{sum: out_sum, cout: out_cout, ovf: out_ovf, tag: out_tag};
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_stable", {out_valid, act_r}, {1'b1, prev_r});
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", out_valid, 1'b0);
                end else begin
                    check("result", act_r, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_outputs_zero", act_r, '0);
            end
            prev_hold = out_valid & ~out_ready;
            prev_r    = act_r;
            if (in_valid && in_ready) begin
`ifdef KS_TAG_EN
                exp_q.push_back(model(in_g, in_p, in_cin, in_tag));
`else
                exp_q.push_back(model(in_g, in_p, in_cin, '0));
`endif
            end
        end
    end

    // One isolated transaction on an empty pipe with literal expectations.
    // The accept edge is the first of the LAT edges, so the result appears after LAT-1 further edges.
    task automatic single(input string name, input logic [W-1:0] g, input logic [W-1:0] p,
                          input logic ci, input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_ovf);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(1'b1, g, p, ci, 4'h9);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b0, '0);
        repeat (LAT - 2) @(posedge clk);
        #1;
        check({name, "_not_early"}, out_valid, 1'b0);
        @(posedge clk); #1;
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_sum"},   out_sum,   e_sum);
        check({name, "_cout"},  out_cout,  e_cout);
        check({name, "_ovf"},   out_ovf,   e_ovf);
`ifdef KS_TAG_EN
        check({name, "_tag"},   out_tag,   4'h9);
`endif
    endtask

    int acc;

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum",   out_sum,   16'h0000);
        check("rst_out_cout",  out_cout,  1'b0);
        check("rst_out_ovf",   out_ovf,   1'b0);
        check("rst_out_tag",   out_tag,   4'h0);
        check("rst_in_ready",  in_ready,  1'b1);

        // 0xFFFF + 0x0001: carry ripples through every bit
        single("ripple", 16'h0001, 16'hFFFE, 1'b0, 16'h0000, 1'b1, 1'b0);
        // 0x7FFF + 0x0001: signed overflow
        single("ovf", 16'h0001, 16'h7FFE, 1'b0, 16'h8000, 1'b0, 1'b1);
        // 0 + 0 + cin
        single("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        // g&p=1 everywhere: every carry is 1 except c0
        single("gp_overlap", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0);
        // 0x8000 + 0x8000: negative overflow, carry out
        single("neg_ovf", 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // streaming: 100 back-to-back, results on negedges 5..104 relative to the first drive
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 107; i++) begin
            if (i < 100) drive_rand(1'b1);
            else         drive(1'b0, '0, '0, 1'b0, '0);
            @(negedge clk);
            check("stream_in_ready", in_ready, 1'b1);
            check("stream_out_valid", out_valid, 1'((i >= 5) && (i <= 104)));
            @(posedge clk); #1;
        end

        // backpressure: capacity is exactly LAT entries
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            drive_rand(1'b1);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        check("bp_accepts", acc, LAT);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_no_gap", out_valid, 1'b1);
            @(posedge clk); #1;
            drive_rand(1'b1);
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        repeat (LAT + 2) @(posedge clk);
        #1;

        // random stall
        for (int i = 0; i < 2000; i++) begin
            drive_rand(1'($urandom_range(1)));
            out_ready = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        out_ready = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("random_drained", exp_q.size(), 0);

        // reset with three entries in flight; in_valid held high during reset must be ignored
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive_rand(1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_outputs",   {out_sum, out_cout, out_ovf, out_tag}, '0);
        check("midrst_in_ready",  in_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 1'b0);
        end
        single("post_rst", 16'h0001, 16'hFFFE, 1'b0, 16'h0000, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
